// File: rtl/reg_writeback_queue_pkg.sv
// rtl/reg_writeback_queue_pkg.sv - shared constants and helpers for the writeback queue
package reg_writeback_queue_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam int REG_ZERO = 0;

  // Width needed to hold an occupancy value in 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wbq_fifo.sv
// rtl/wbq_fifo.sv - circular storage for pending register writes with per-entry valid vector
module wbq_fifo
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [AW-1:0]                push_addr,
  input  logic [DW-1:0]                push_data,
  output logic [AW-1:0]                head_addr,
  output logic [DW-1:0]                head_data,
  output logic [cnt_w(DEPTH)-1:0]      count,
  output logic                         full,
  output logic                         empty,
  output logic [PW-1:0]                rd_ptr,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][AW-1:0]     mem_addr,
  output logic [DEPTH-1:0][DW-1:0]     mem_data
);

  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0] wr_ptr;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Pointers and occupancy; clear wins over any concurrent push/pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents are qualified by entry_valid so no reset is needed
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // An entry is live when its distance from the head is below the occupancy
  always_comb begin
    entry_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [PW-1:0] offs;
      offs = PW'(k) - rd_ptr;
      entry_valid[k] = (CW'(offs) < count);
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - buffered register-file write initiator with forwarding lookup
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AW-1:0]           in_addr,
  input  logic [DW-1:0]           in_data,
  input  logic                    hold,
  input  logic                    flush,
  output logic                    enc,
  output logic [AW-1:0]           addrc,
  output logic [DW-1:0]           datac,
  input  logic [AW-1:0]           fwd_addr,
  output logic                    fwd_hit,
  output logic [DW-1:0]           fwd_data,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic                     full, empty, push, pop;
  logic [AW-1:0]            head_addr;
  logic [DW-1:0]            head_data;
  logic [PW-1:0]            rd_ptr;
  logic [DEPTH-1:0]         entry_valid;
  logic [DEPTH-1:0][AW-1:0] mem_addr;
  logic [DEPTH-1:0][DW-1:0] mem_data;

  // Full blocks input even if a pop happens this edge; writes to r0 are accepted and dropped
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready && (in_addr != AW'(REG_ZERO));
  assign pop      = !empty && !hold && !flush;

  wbq_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .clear       (flush),
    .push_addr   (in_addr),
    .push_data   (in_data),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .rd_ptr      (rd_ptr),
    .entry_valid (entry_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data)
  );

  // Output stage: one register-file write per popped entry, address/data held when idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enc   <= 1'b0;
      addrc <= '0;
      datac <= '0;
    end else if (pop) begin
      enc   <= 1'b1;
      addrc <= head_addr;
      datac <= head_data;
    end else begin
      enc   <= 1'b0;
    end
  end

  // Forward search from oldest to youngest so the last match (youngest) wins
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (fwd_addr != AW'(REG_ZERO)) begin
      if (enc && (addrc == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = datac;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if (entry_valid[idx] && (mem_addr[idx] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = mem_data[idx];
        end
      end
    end
  end

endmodule
